// File: rtl/mux_bist_ctrl.sv
// Built-in self-test controller for a 2:1 32-bit mux: LFSR-driven vectors, result counters
// and first-failure capture. Define MUX_BIST_SIGNATURE_EN to add a MISR signature of mux_c.
module mux_bist_ctrl #(
  parameter int          NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'hACE12468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] mux_a,
  output logic [31:0] mux_b,
  output logic        mux_s,
  input  logic [31:0] mux_c,
  input  logic        mux_err,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] mismatch_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] first_fail_idx,
  output logic [31:0] signature
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
  localparam logic [31:0] POLY     = 32'h8020_0003;
  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [31:0] galois_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? POLY : 32'h0);
  endfunction

  function automatic logic [31:0] map_b(input logic [31:0] l);
    return {l[15:0], l[31:16]} ^ 32'h5A5A_5A5A;
  endfunction

  state_t      state;
  logic [31:0] lfsr;
  logic [31:0] lfsr_next;
  logic [15:0] vec_idx;
  logic [31:0] expected;
  logic        mismatch;
  logic        fail;

  // The mux response is checked in the same cycle its vector is on the drive registers.
  always_comb begin
    lfsr_next = galois_step(lfsr);
    expected  = mux_s ? mux_b : mux_a;
    mismatch  = (mux_c != expected);
    fail      = mismatch | mux_err;
  end

  assign pass = done && (mismatch_cnt == 16'h0) && (err_cnt == 16'h0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      lfsr           <= SEED_EFF;
      vec_idx        <= 16'h0;
      mux_a          <= 32'h0;
      mux_b          <= 32'h0;
      mux_s          <= 1'b0;
      mismatch_cnt   <= 16'h0;
      err_cnt        <= 16'h0;
      first_fail_idx <= 16'hFFFF;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= RUN;
            busy           <= 1'b1;
            done           <= 1'b0;
            lfsr           <= SEED_EFF;
            vec_idx        <= 16'h0;
            mux_a          <= SEED_EFF;
            mux_b          <= map_b(SEED_EFF);
            mux_s          <= SEED_EFF[0] ^ SEED_EFF[31];
            mismatch_cnt   <= 16'h0;
            err_cnt        <= 16'h0;
            first_fail_idx <= 16'hFFFF;
          end
        end
        RUN: begin
          if (mismatch && (mismatch_cnt != 16'hFFFF))
            mismatch_cnt <= mismatch_cnt + 16'd1;
          if (mux_err && (err_cnt != 16'hFFFF))
            err_cnt <= err_cnt + 16'd1;
          if (fail && (first_fail_idx == 16'hFFFF))
            first_fail_idx <= vec_idx;
          lfsr <= lfsr_next;
          // Drive registers return to zero once the final vector has been checked.
          if (vec_idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            mux_a <= 32'h0;
            mux_b <= 32'h0;
            mux_s <= 1'b0;
          end else begin
            vec_idx <= vec_idx + 16'd1;
            mux_a   <= lfsr_next;
            mux_b   <= map_b(lfsr_next);
            mux_s   <= lfsr_next[0] ^ lfsr_next[31];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUX_BIST_SIGNATURE_EN
  // MISR compacts every mux response of the run; it only moves while vectors are applied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      signature <= 32'h0;
    end else if ((state != RUN) && start) begin
      signature <= 32'h0;
    end else if (state == RUN) begin
      signature <= galois_step(signature) ^ mux_c;
    end
  end
`else
  assign signature = 32'h0;
`endif

endmodule

// File: tb/tb_mux_bist_ctrl.sv
// Self-checking bench for mux_bist_ctrl: golden/faulty mux models against a loop-based
// reference of the vector sequence and result registers.
module tb_mux_bist_ctrl;

  localparam int          N    = 256;
  localparam logic [31:0] SEED = 32'hACE12468;
  localparam logic [31:0] POLY = 32'h8020_0003;

  typedef struct packed {
    logic [15:0] mism;
    logic [15:0] errs;
    logic [15:0] ffi;
    logic [31:0] sig;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] mux_a, mux_b, mux_c;
  logic        mux_s, mux_err;
  logic        busy, done, pass;
  logic [15:0] mismatch_cnt, err_cnt, first_fail_idx;
  logic [31:0] signature;

  logic        start_1;
  logic [31:0] mux_a_1, mux_b_1, mux_c_1;
  logic        mux_s_1, mux_err_1;
  logic        busy_1, done_1, pass_1;
  logic [15:0] mismatch_cnt_1, err_cnt_1, first_fail_idx_1;
  logic [31:0] signature_1;

  int          fault_mode;
  logic [31:0] err_vec;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // Mux under test: golden 2:1 mux, optionally with bit 7 stuck high or an error flag on one vector.
  always_comb begin
    mux_c = mux_s ? mux_b : mux_a;
    if (fault_mode == 1) mux_c[7] = 1'b1;
    mux_err = (fault_mode == 2) && (mux_a == err_vec);
  end

  always_comb begin
    mux_c_1   = mux_s_1 ? mux_b_1 : mux_a_1;
    mux_err_1 = 1'b0;
  end

  mux_bist_ctrl #(.NUM_VECTORS(N), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mux_a(mux_a), .mux_b(mux_b), .mux_s(mux_s), .mux_c(mux_c), .mux_err(mux_err),
    .busy(busy), .done(done), .pass(pass),
    .mismatch_cnt(mismatch_cnt), .err_cnt(err_cnt), .first_fail_idx(first_fail_idx),
    .signature(signature)
  );

  mux_bist_ctrl #(.NUM_VECTORS(1), .SEED(32'h0)) dut_1 (
    .clk(clk), .rst(rst), .start(start_1),
    .mux_a(mux_a_1), .mux_b(mux_b_1), .mux_s(mux_s_1), .mux_c(mux_c_1), .mux_err(mux_err_1),
    .busy(busy_1), .done(done_1), .pass(pass_1),
    .mismatch_cnt(mismatch_cnt_1), .err_cnt(err_cnt_1), .first_fail_idx(first_fail_idx_1),
    .signature(signature_1)
  );

  function automatic logic [31:0] step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? POLY : 32'h0);
  endfunction

  function automatic logic [31:0] vec_at(input logic [31:0] seed, input int k);
    logic [31:0] l;
    l = (seed == 32'h0) ? 32'h1 : seed;
    for (int i = 0; i < k; i++) l = step(l);
    return l;
  endfunction

  // Whole-run reference: walks the vector sequence and accumulates what the controller should report.
  function automatic res_t model_run(input logic [31:0] seed, input int n, input int mode);
    res_t        r;
    logic [31:0] l, b, e, c;
    logic        s, bad_m, bad_e;
    r = '{mism: 16'h0, errs: 16'h0, ffi: 16'hFFFF, sig: 32'h0};
    l = (seed == 32'h0) ? 32'h1 : seed;
    for (int k = 0; k < n; k++) begin
      b = {l[15:0], l[31:16]} ^ 32'h5A5A_5A5A;
      s = l[0] ^ l[31];
      e = s ? b : l;
      c = e;
      if (mode == 1) c[7] = 1'b1;
      bad_m = (c != e);
      bad_e = (mode == 2) && (k == 10);
      if (bad_m && r.mism != 16'hFFFF) r.mism = r.mism + 16'd1;
      if (bad_e && r.errs != 16'hFFFF) r.errs = r.errs + 16'd1;
      if ((bad_m || bad_e) && r.ffi == 16'hFFFF) r.ffi = 16'(k);
      r.sig = step(r.sig) ^ c;
      l = step(l);
    end
`ifndef MUX_BIST_SIGNATURE_EN
    r.sig = 32'h0;
`endif
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launches one run from IDLE/DONE, pokes ignored starts, probes one vector, then checks results.
  task automatic apply_stimulus(input string name, input int mode, input int ig_a, input int ig_b,
                                output logic [31:0] sig_out);
    int          cycles;
    int          probe;
    res_t        r;
    logic [31:0] l;
    r          = model_run(SEED, N, mode);
    probe      = $urandom_range(1, N - 1);
    fault_mode = mode;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < N + 10) begin
      if (cycles == 0) begin
        check_output({name, "_clr_mism"}, 32'(mismatch_cnt), 32'h0);
        check_output({name, "_clr_ffi"}, 32'(first_fail_idx), 32'hFFFF);
      end
      if (cycles == probe) begin
        l = vec_at(SEED, probe);
        check_output({name, "_vec_a"}, mux_a, l);
        check_output({name, "_vec_b"}, mux_b, {l[15:0], l[31:16]} ^ 32'h5A5A_5A5A);
        check_output({name, "_vec_s"}, 32'(mux_s), 32'(l[0] ^ l[31]));
      end
      start = (cycles == ig_a) || (cycles == ig_b);
      cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    check_output({name, "_busy_cycles"}, 32'(cycles), 32'(N));
    check_output({name, "_done"}, 32'(done), 32'h1);
    check_output({name, "_pass"}, 32'(pass), 32'((r.mism == 0) && (r.errs == 0)));
    check_output({name, "_mism"}, 32'(mismatch_cnt), 32'(r.mism));
    check_output({name, "_errs"}, 32'(err_cnt), 32'(r.errs));
    check_output({name, "_ffi"}, 32'(first_fail_idx), 32'(r.ffi));
    check_output({name, "_sig"}, signature, r.sig);
    check_output({name, "_idle_a"}, mux_a, 32'h0);
    sig_out = signature;
  endtask

  task automatic check_reset_state(input string name);
    check_output({name, "_busy"}, 32'(busy), 32'h0);
    check_output({name, "_done"}, 32'(done), 32'h0);
    check_output({name, "_pass"}, 32'(pass), 32'h0);
    check_output({name, "_a"}, mux_a, 32'h0);
    check_output({name, "_b"}, mux_b, 32'h0);
    check_output({name, "_s"}, 32'(mux_s), 32'h0);
    check_output({name, "_mism"}, 32'(mismatch_cnt), 32'h0);
    check_output({name, "_errs"}, 32'(err_cnt), 32'h0);
    check_output({name, "_ffi"}, 32'(first_fail_idx), 32'hFFFF);
    check_output({name, "_sig"}, signature, 32'h0);
  endtask

  initial begin
    logic [31:0] sig_clean, sig_stuck, sig_again, sig_tmp;
    logic [15:0] held_mism;
    int          cycles;
    res_t        r1;
    rst        = 1'b0;
    start      = 1'b0;
    start_1    = 1'b0;
    fault_mode = 0;
    err_vec    = vec_at(SEED, 10);

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;
    repeat ($urandom_range(1, 6)) @(negedge clk);

    $display("[TB] clean run with starts at RUN cycles 5 and 50");
    apply_stimulus("clean", 0, 5, 50, sig_clean);

    held_mism = mismatch_cnt;
    repeat ($urandom_range(3, 12)) @(negedge clk);
    check_output("done_hold", 32'(done), 32'h1);
    check_output("done_hold_mism", 32'(mismatch_cnt), 32'(held_mism));
    check_output("done_hold_sig", signature, sig_clean);

    $display("[TB] stuck-at-1 on bit 7");
    apply_stimulus("stuck", 1, $urandom_range(1, 120), $urandom_range(121, 250), sig_stuck);

    $display("[TB] restart from DONE with golden mux");
    apply_stimulus("restart", 0, -1, -1, sig_tmp);

    $display("[TB] error flag at vector 10");
    apply_stimulus("errflag", 2, $urandom_range(11, 250), -1, sig_tmp);

    $display("[TB] reset asserted at vector 100");
    fault_mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (100) @(negedge clk);
    check_output("abort_running", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    check_reset_state("abort");
    start = 1'b1;
    repeat (3) @(negedge clk);
    check_output("abort_start_ignored", 32'(busy), 32'h0);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check_output("abort_idle_after", 32'(busy), 32'h0);
    apply_stimulus("post_abort", 0, -1, -1, sig_again);
    check_output("post_abort_sig_match", sig_again, sig_clean);

`ifdef MUX_BIST_SIGNATURE_EN
    check_output("sig_nonzero", 32'(sig_clean != 32'h0), 32'h1);
    check_output("sig_fault_differs", 32'(sig_stuck != sig_clean), 32'h1);
`endif

    $display("[TB] single-vector instance with zero seed");
    r1 = model_run(32'h0, 1, 0);
    @(negedge clk) start_1 = 1'b1;
    @(negedge clk) start_1 = 1'b0;
    check_output("nv1_first_vec", mux_a_1, 32'h1);
    cycles = 0;
    while (busy_1 === 1'b1 && cycles < 10) begin
      cycles++;
      @(negedge clk);
    end
    check_output("nv1_busy_cycles", 32'(cycles), 32'h1);
    check_output("nv1_done", 32'(done_1), 32'h1);
    check_output("nv1_pass", 32'(pass_1), 32'h1);
    check_output("nv1_mism", 32'(mismatch_cnt_1), 32'(r1.mism));
    check_output("nv1_errs", 32'(err_cnt_1), 32'(r1.errs));
    check_output("nv1_ffi", 32'(first_fail_idx_1), 32'(r1.ffi));
    check_output("nv1_sig", signature_1, r1.sig);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
